// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: registered load/store with byte/half/word lanes,
// LL/SC reservation and a DataMem_Ack handshake with optional timeout.
module dmem_access_ctrl #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Byte,
    input  logic              Half,
    input  logic              SignExtend,
    input  logic              LLSC,
    input  logic              ERET,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    input  logic [31:0]       MReadData,
    input  logic              DataMem_Ack,
    output logic [ADDR_W-1:0] MAddress,
    output logic [31:0]       MWriteData,
    output logic [3:0]        ByteEnable,
    output logic              ReadEnable,
    output logic              WriteEnable,
    output logic [31:0]       DataOut,
    output logic              Done,
    output logic              M_Stall,
    output logic              EXC_AdEL,
    output logic              EXC_AdES,
    output logic              EXC_BusErr
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit HAS_TIMEOUT = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   maddr_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         dout_reg;
    logic [3:0]          be_reg;
    logic                rd_en_reg, wr_en_reg, bus_err_reg;
    logic                is_read_reg, is_ll_reg, is_sc_reg;
    logic                is_byte_reg, is_half_reg, sext_reg;
    logic [1:0]          off_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                ll_bit_reg;
    logic [ADDR_W-3:0]   ll_addr_reg;

    // Request decode, evaluated against the live pipeline inputs
    logic        req, misaligned, accept, sc_fail;
    logic [1:0]  req_lane;
    logic        req_half_hi;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    assign req         = MemRead ^ MemWrite;
    assign misaligned  = Byte ? 1'b0 : (Half ? Address[0] : (Address[1:0] != 2'b00));
    assign accept      = RST && (state_reg == IDLE) && req && !misaligned;
    assign sc_fail     = MemWrite && !MemRead && LLSC &&
                         (!ll_bit_reg || (Address[ADDR_W-1:2] != ll_addr_reg));
    assign req_lane    = BIG_ENDIAN ? ~Address[1:0] : Address[1:0];
    assign req_half_hi = BIG_ENDIAN ? ~Address[1] : Address[1];

    always_comb begin
        req_be    = 4'b1111;
        req_wdata = DataIn;
        if (Byte) begin
            req_be    = 4'b0001 << req_lane;
            req_wdata = {4{DataIn[7:0]}};
        end else if (Half) begin
            req_be    = req_half_hi ? 4'b1100 : 4'b0011;
            req_wdata = {2{DataIn[15:0]}};
        end
    end

    // Load lane selection from the latched offset
    logic [7:0]  rd_bytes [4];
    logic [1:0]  ld_lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_bytes[gi] = MReadData[8*gi +: 8];
        end
    endgenerate

    assign ld_lane = BIG_ENDIAN ? ~off_reg : off_reg;
    assign ld_byte = rd_bytes[ld_lane];
    assign ld_half = ((BIG_ENDIAN ? ~off_reg[1] : off_reg[1]) != 1'b0) ? MReadData[31:16]
                                                                       : MReadData[15:0];

    always_comb begin
        ld_data = MReadData;
        if (is_byte_reg)
            ld_data = {{24{sext_reg & ld_byte[7]}}, ld_byte};
        else if (is_half_reg)
            ld_data = {{16{sext_reg & ld_half[15]}}, ld_half};
    end

    // Next-state logic
    logic ack_hit, expire;

    always_comb begin
        state_next = state_reg;
        ack_hit    = 1'b0;
        expire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = sc_fail ? COMPLETE : ACCESS;
            end
            ACCESS: begin
                if (DataMem_Ack) begin
                    ack_hit    = 1'b1;
                    state_next = COMPLETE;
                end else if (HAS_TIMEOUT && (cnt_reg == CNT_LAST)) begin
                    expire     = 1'b1;
                    state_next = COMPLETE;
                end
            end
            COMPLETE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            maddr_reg   <= '0;
            wdata_reg   <= '0;
            dout_reg    <= '0;
            be_reg      <= '0;
            rd_en_reg   <= 1'b0;
            wr_en_reg   <= 1'b0;
            bus_err_reg <= 1'b0;
            is_read_reg <= 1'b0;
            is_ll_reg   <= 1'b0;
            is_sc_reg   <= 1'b0;
            is_byte_reg <= 1'b0;
            is_half_reg <= 1'b0;
            sext_reg    <= 1'b0;
            off_reg     <= '0;
            cnt_reg     <= '0;
            ll_bit_reg  <= 1'b0;
            ll_addr_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                maddr_reg   <= {Address[ADDR_W-1:2], 2'b00};
                wdata_reg   <= req_wdata;
                be_reg      <= req_be;
                is_read_reg <= MemRead;
                is_ll_reg   <= MemRead & LLSC;
                is_sc_reg   <= MemWrite & LLSC;
                is_byte_reg <= Byte;
                is_half_reg <= Half & !Byte;
                sext_reg    <= SignExtend;
                off_reg     <= Address[1:0];
                cnt_reg     <= '0;
                bus_err_reg <= 1'b0;
                if (sc_fail) begin
                    dout_reg <= '0;
                end else begin
                    rd_en_reg <= MemRead;
                    wr_en_reg <= MemWrite;
                end
            end

            if (state_reg == ACCESS)
                cnt_reg <= cnt_reg + 1'b1;

            if (ack_hit) begin
                rd_en_reg <= 1'b0;
                wr_en_reg <= 1'b0;
                if (is_read_reg)
                    dout_reg <= ld_data;
                else if (is_sc_reg)
                    dout_reg <= 32'd1;
            end else if (expire) begin
                rd_en_reg   <= 1'b0;
                wr_en_reg   <= 1'b0;
                dout_reg    <= '0;
                bus_err_reg <= 1'b1;
            end

            // ERET beats a reservation set in the same cycle
            if (ERET) begin
                ll_bit_reg <= 1'b0;
            end else if (ack_hit && is_ll_reg) begin
                ll_bit_reg  <= 1'b1;
                ll_addr_reg <= maddr_reg[ADDR_W-1:2];
            end else if (ack_hit && !is_read_reg && (maddr_reg[ADDR_W-1:2] == ll_addr_reg)) begin
                ll_bit_reg <= 1'b0;
            end
        end
    end

    assign MAddress    = maddr_reg;
    assign MWriteData  = wdata_reg;
    assign ByteEnable  = be_reg;
    assign ReadEnable  = rd_en_reg;
    assign WriteEnable = wr_en_reg;
    assign DataOut     = dout_reg;
    assign Done        = (state_reg == COMPLETE);
    assign M_Stall     = accept || (state_reg == ACCESS);
    assign EXC_AdEL    = RST && (state_reg == IDLE) && MemRead && !MemWrite && misaligned;
    assign EXC_AdES    = RST && (state_reg == IDLE) && MemWrite && !MemRead && misaligned;
    assign EXC_BusErr  = Done && bus_err_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl (big-endian, TIMEOUT=4) with an expected-result queue.
module tb_dmem_access_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MemRead = 0, MemWrite = 0, Byte = 0, Half = 0, SignExtend = 0, LLSC = 0, ERET = 0;
    logic [31:0] Address = '0, DataIn = '0, MReadData = '0;
    logic        DataMem_Ack = 1'b0;
    logic [31:0] MAddress, MWriteData, DataOut;
    logic [3:0]  ByteEnable;
    logic        ReadEnable, WriteEnable, Done, M_Stall, EXC_AdEL, EXC_AdES, EXC_BusErr;

    dmem_access_ctrl #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .Byte(Byte), .Half(Half),
        .SignExtend(SignExtend), .LLSC(LLSC), .ERET(ERET), .Address(Address), .DataIn(DataIn),
        .MReadData(MReadData), .DataMem_Ack(DataMem_Ack), .MAddress(MAddress),
        .MWriteData(MWriteData), .ByteEnable(ByteEnable), .ReadEnable(ReadEnable),
        .WriteEnable(WriteEnable), .DataOut(DataOut), .Done(Done), .M_Stall(M_Stall),
        .EXC_AdEL(EXC_AdEL), .EXC_AdES(EXC_AdES), .EXC_BusErr(EXC_BusErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] dout;
        bit          chk_dout;
        bit          berr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        MemRead = 0; MemWrite = 0; Byte = 0; Half = 0; SignExtend = 0; LLSC = 0;
        Address = '0; DataIn = '0; DataMem_Ack = 0;
    endtask

    // Drives one request at a negedge and follows it to Done; ack_at = ACCESS cycle of the ack (0 = never)
    task automatic run_access(input string tag, input bit rd, input bit wr, input bit by,
                              input bit hf, input bit sx, input bit ls,
                              input logic [31:0] addr, input logic [31:0] din,
                              input logic [31:0] rdata, input int ack_at,
                              input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input bit chk_dout,
                              input logic [31:0] exp_dout, input bit exp_berr,
                              input int exp_acc, input int exp_stall);
        exp_t e;
        int   stall = 0;
        int   acc = 0;
        bit   done_seen = 0;
        e.tag = tag; e.dout = exp_dout; e.chk_dout = chk_dout; e.berr = exp_berr;
        exp_q.push_back(e);
        MemRead = rd; MemWrite = wr; Byte = by; Half = hf; SignExtend = sx; LLSC = ls;
        Address = addr; DataIn = din; MReadData = rdata;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            #1;
            if (M_Stall) stall++;
            if (ReadEnable || WriteEnable) begin
                acc++;
                if (acc == 1) begin
                    check({tag, "/maddr"}, MAddress, exp_maddr);
                    check({tag, "/be"}, {28'd0, ByteEnable}, {28'd0, exp_be});
                    check({tag, "/wdata"}, MWriteData, exp_wd);
                    check({tag, "/rd_en"}, {31'd0, ReadEnable}, {31'd0, rd});
                    check({tag, "/wr_en"}, {31'd0, WriteEnable}, {31'd0, wr});
                end
            end
            DataMem_Ack = (ReadEnable || WriteEnable) && (acc == ack_at);
            if (Done) begin
                exp_t got;
                done_seen = 1;
                got = exp_q.pop_front();
                if (got.chk_dout) check({got.tag, "/dout"}, DataOut, got.dout);
                check({got.tag, "/buserr"}, {31'd0, EXC_BusErr}, {31'd0, got.berr});
                check({got.tag, "/stall_done"}, {31'd0, M_Stall}, 32'd0);
            end else begin
                @(negedge CLK);
            end
        end
        check({tag, "/done_seen"}, {31'd0, done_seen}, 32'd1);
        check({tag, "/access_cycles"}, acc, exp_acc);
        check({tag, "/stall_cycles"}, stall, exp_stall);
        $display("txn %s: dout=%h berr=%0b access=%0d stall=%0d", tag, DataOut, EXC_BusErr, acc, stall);
        clear_req();
        @(negedge CLK);
    endtask

    // Misaligned request: exception this cycle, no stall, no strobe while held
    task automatic run_misaligned(input string tag, input bit rd, input bit hf,
                                  input logic [31:0] addr);
        MemRead = rd; MemWrite = !rd; Half = hf; Address = addr; DataIn = 32'h1234;
        #1;
        check({tag, "/adel"}, {31'd0, EXC_AdEL}, {31'd0, rd});
        check({tag, "/ades"}, {31'd0, EXC_AdES}, {31'd0, !rd});
        check({tag, "/stall"}, {31'd0, M_Stall}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            check({tag, "/no_strobe"}, {30'd0, ReadEnable, WriteEnable}, 32'd0);
            check({tag, "/no_done"}, {31'd0, Done}, 32'd0);
        end
        $display("txn %s: misaligned addr=%h adel=%0b ades=%0b", tag, addr, EXC_AdEL, EXC_AdES);
        clear_req();
        @(negedge CLK);
    endtask

    initial begin
        clear_req();
        @(negedge CLK); #1;
        check("reset/outs", {ReadEnable, WriteEnable, Done, M_Stall, EXC_BusErr, EXC_AdEL, EXC_AdES},
              32'd0);
        check("reset/dout", DataOut, 32'd0);
        check("reset/maddr", MAddress, 32'd0);
        check("reset/be_wd", MWriteData | {28'd0, ByteEnable}, 32'd0);
        $display("txn reset: outputs checked");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        //         tag        rd wr by hf sx ls addr          din           rdata         ack maddr         be       wd            chk dout          berr acc stall
        run_access("lw",      1, 0, 0, 0, 0, 0, 32'h100,      32'h0,        32'hDEADBEEF, 2,  32'h100,      4'b1111, 32'h0,        1,  32'hDEADBEEF, 0,   2,  3);
        run_access("lb_s",    1, 0, 1, 0, 1, 0, 32'h103,      32'h0,        32'h000000F0, 1,  32'h100,      4'b0001, 32'h0,        1,  32'hFFFFFFF0, 0,   1,  2);
        run_access("lbu",     1, 0, 1, 0, 0, 0, 32'h100,      32'h0,        32'h8A000000, 1,  32'h100,      4'b1000, 32'h0,        1,  32'h0000008A, 0,   1,  2);
        run_access("lh_s",    1, 0, 0, 1, 1, 0, 32'h102,      32'h0,        32'h12348001, 1,  32'h100,      4'b0011, 32'h0,        1,  32'hFFFF8001, 0,   1,  2);
        run_access("lhu_hi",  1, 0, 0, 1, 0, 0, 32'h204,      32'h0,        32'hC0DE0000, 1,  32'h204,      4'b1100, 32'h0,        1,  32'h0000C0DE, 0,   1,  2);
        run_access("sh",      0, 1, 0, 1, 0, 0, 32'h102,      32'h1234,     32'h0,        3,  32'h100,      4'b0011, 32'h12341234, 0,  32'h0,        0,   3,  4);
        run_access("sb",      0, 1, 1, 0, 0, 0, 32'h101,      32'hAB,       32'h0,        1,  32'h100,      4'b0100, 32'hABABABAB, 0,  32'h0,        0,   1,  2);

        run_misaligned("lw_mis", 1, 0, 32'h102);
        run_misaligned("sh_mis", 0, 1, 32'h101);

        // MemRead and MemWrite together are ignored
        MemRead = 1; MemWrite = 1; Address = 32'h100;
        #1;
        check("rw_both/stall", {31'd0, M_Stall}, 32'd0);
        @(negedge CLK); #1;
        check("rw_both/no_strobe", {30'd0, ReadEnable, WriteEnable}, 32'd0);
        $display("txn rw_both: ignored");
        clear_req();
        @(negedge CLK);

        // Ack while idle is ignored
        DataMem_Ack = 1;
        @(negedge CLK); #1;
        check("idle_ack/done", {31'd0, Done}, 32'd0);
        $display("txn idle_ack: ignored");
        DataMem_Ack = 0;
        @(negedge CLK);

        run_access("ll",      1, 0, 0, 0, 0, 1, 32'h200,      32'h0,        32'h00000055, 1,  32'h200,      4'b1111, 32'h0,        1,  32'h00000055, 0,   1,  2);
        run_access("sc_ok",   0, 1, 0, 0, 0, 1, 32'h200,      32'h7,        32'h0,        1,  32'h200,      4'b1111, 32'h7,        1,  32'h1,        0,   1,  2);
        run_access("sc_again",0, 1, 0, 0, 0, 1, 32'h200,      32'h7,        32'h0,        1,  32'h0,        4'b0000, 32'h0,        1,  32'h0,        0,   0,  1);

        run_access("ll2",     1, 0, 0, 0, 0, 1, 32'h300,      32'h0,        32'h11111111, 1,  32'h300,      4'b1111, 32'h0,        1,  32'h11111111, 0,   1,  2);
        ERET = 1;
        @(negedge CLK);
        ERET = 0;
        run_access("sc_eret", 0, 1, 0, 0, 0, 1, 32'h300,      32'h9,        32'h0,        1,  32'h0,        4'b0000, 32'h0,        1,  32'h0,        0,   0,  1);

        run_access("ll3",     1, 0, 0, 0, 0, 1, 32'h400,      32'h0,        32'h22222222, 1,  32'h400,      4'b1111, 32'h0,        1,  32'h22222222, 0,   1,  2);
        run_access("sw_ll",   0, 1, 0, 0, 0, 0, 32'h400,      32'h33,       32'h0,        1,  32'h400,      4'b1111, 32'h33,       0,  32'h0,        0,   1,  2);
        run_access("sc_clr",  0, 1, 0, 0, 0, 1, 32'h400,      32'h44,       32'h0,        1,  32'h0,        4'b0000, 32'h0,        1,  32'h0,        0,   0,  1);

        run_access("timeout", 1, 0, 0, 0, 0, 0, 32'h500,      32'h0,        32'hFFFFFFFF, 0,  32'h500,      4'b1111, 32'h0,        1,  32'h0,        1,   4,  5);
        run_access("ack_edge",1, 0, 0, 0, 0, 0, 32'h504,      32'h0,        32'hA5A5A5A5, 4,  32'h504,      4'b1111, 32'h0,        1,  32'hA5A5A5A5, 0,   4,  5);

        // Reset in the middle of ACCESS drops strobes at once
        MemRead = 1; Address = 32'h600;
        @(negedge CLK);
        @(negedge CLK); #1;
        check("rst_mid/rd_before", {31'd0, ReadEnable}, 32'd1);
        RST = 1'b0;
        #1;
        check("rst_mid/rd_en", {31'd0, ReadEnable}, 32'd0);
        check("rst_mid/stall", {31'd0, M_Stall}, 32'd0);
        check("rst_mid/maddr", MAddress, 32'd0);
        check("rst_mid/dout", DataOut, 32'd0);
        $display("txn rst_mid: strobes dropped");
        clear_req();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
